// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - 2-wide physical register free list (optional checkpoint: FREE_LIST_CKPT_EN)
module phys_reg_free_list #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int TAG_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alloc_req,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag_a,
  output logic [TAG_W-1:0] alloc_tag_b,
  input  logic [1:0]       free_valid,
  input  logic [TAG_W-1:0] free_tag_a,
  input  logic [TAG_W-1:0] free_tag_b,
  output logic [TAG_W:0]   free_count,
  output logic             overflow,
  output logic             stall
`ifdef FREE_LIST_CKPT_EN
  ,
  input  logic             ckpt_save,
  input  logic             ckpt_restore,
  output logic             ckpt_valid
`endif
);

  localparam int            NUM_INIT = NUM_PHYS - NUM_ARCH;
  localparam logic [TAG_W:0] CAP     = (TAG_W+1)'(NUM_PHYS);

  logic [TAG_W-1:0] entry_q [NUM_PHYS];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W-1:0] head_p1, tail_b;
  logic [TAG_W:0]   count_q, count_d;
  logic [TAG_W:0]   n_alloc, n_grant, n_free, n_free_acc;
  logic             overflow_q, overflow_d;
  logic             grant, free_a_ok, free_b_ok, free_accept;
  logic             restore_fire, zero_en;
  logic [TAG_W:0]   restore_count;

`ifdef FREE_LIST_CKPT_EN
  logic [TAG_W-1:0] ckpt_head_q;
  logic             ckpt_valid_q;
  logic             ckpt_alloc_q;  // any grant since the save: disambiguates a zero distance as full
  logic [TAG_W-1:0] restore_diff;

  // Restore target: checkpointed head, count rebuilt from the post-release tail
  always_comb begin
    restore_fire  = ckpt_restore & ckpt_valid_q;
    zero_en       = ~ckpt_valid_q;
    restore_diff  = tail_d - ckpt_head_q;
    restore_count = {1'b0, restore_diff};
    if (restore_diff == '0)
      restore_count = ((count_q + n_free_acc) != '0 || ckpt_alloc_q) ? CAP : '0;
  end

  // Checkpoint register: restore wins over a same-cycle save
  always_ff @(posedge clk) begin
    if (reset) begin
      ckpt_head_q  <= '0;
      ckpt_valid_q <= 1'b0;
      ckpt_alloc_q <= 1'b0;
    end else if (restore_fire) begin
      ckpt_valid_q <= 1'b0;
      ckpt_alloc_q <= 1'b0;
    end else if (ckpt_save) begin
      ckpt_head_q  <= head_d;
      ckpt_valid_q <= 1'b1;
      ckpt_alloc_q <= 1'b0;
    end else if (grant && ckpt_valid_q) begin
      ckpt_alloc_q <= 1'b1;
    end
  end

  assign ckpt_valid = ckpt_valid_q;
`else
  assign restore_fire  = 1'b0;
  assign zero_en       = 1'b1;
  assign restore_count = '0;
`endif

  // Release side: drop tag 0, accept the pair only if it fits, pack at tail
  always_comb begin
    free_a_ok   = free_valid[0] & (free_tag_a != '0);
    free_b_ok   = free_valid[1] & (free_tag_b != '0);
    n_free      = (TAG_W+1)'(free_a_ok) + (TAG_W+1)'(free_b_ok);
    free_accept = (count_q + n_free) <= CAP;
    n_free_acc  = free_accept ? n_free : '0;
    tail_b      = tail_q + TAG_W'(free_a_ok);
    tail_d      = tail_q + TAG_W'(n_free_acc);
    overflow_d  = overflow_q | ~free_accept;
  end

  // Allocation side: all-or-nothing grant from head, tag packing, next head/count
  always_comb begin
    n_alloc     = (TAG_W+1)'(alloc_req[0]) + (TAG_W+1)'(alloc_req[1]);
    alloc_ready = ~reset & ~restore_fire & (count_q >= n_alloc);
    grant       = alloc_ready & (|alloc_req);
    n_grant     = grant ? n_alloc : '0;
    head_p1     = head_q + TAG_W'(1);
    alloc_tag_a = '0;
    alloc_tag_b = '0;
    if (grant) begin
      if (alloc_req[0]) alloc_tag_a = entry_q[head_q];
      if (alloc_req[1]) alloc_tag_b = alloc_req[0] ? entry_q[head_p1] : entry_q[head_q];
    end
    head_d  = head_q + TAG_W'(n_grant);
    count_d = count_q - n_grant + n_free_acc;
    if (restore_fire) begin
      head_d  = ckpt_head_sel();
      count_d = restore_count;
    end
    stall = (|alloc_req) & ~alloc_ready;
  end

  function automatic logic [TAG_W-1:0] ckpt_head_sel();
`ifdef FREE_LIST_CKPT_EN
    return ckpt_head_q;
`else
    return head_q;
`endif
  endfunction

  // Queue storage and pointers; consumed slots cleared unless a checkpoint may reuse them
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHYS; i++)
        entry_q[i] <= (i < NUM_INIT) ? TAG_W'(NUM_ARCH + i) : '0;
      head_q     <= '0;
      tail_q     <= TAG_W'(NUM_INIT);
      count_q    <= (TAG_W+1)'(NUM_INIT);
      overflow_q <= 1'b0;
    end else begin
      if (grant && zero_en) begin
        entry_q[head_q] <= '0;
        if (alloc_req == 2'b11) entry_q[head_p1] <= '0;
      end
      if (free_accept) begin
        if (free_a_ok) entry_q[tail_q] <= free_tag_a;
        if (free_b_ok) entry_q[tail_b] <= free_tag_b;
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Invariants: count bounded, granted tags never the x0 marker
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= CAP);
      assert (!(grant && alloc_req[0]) || alloc_tag_a != '0);
      assert (!(grant && alloc_req[1]) || alloc_tag_b != '0);
    end
  end

  assign free_count = count_q;
  assign overflow   = overflow_q;

endmodule
